// File: rtl/diff_mc_pkg.sv
// Shared types and width helpers for the multi-channel first-difference engine.
package diff_mc_pkg;

  // Occupancy of the two-entry output buffer (output register + skid register).
  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_TWO   = 2'd2
  } skid_state_t;

  function automatic int out_width(input int w);
    return w + 1;
  endfunction

  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/diff_mc_if.sv
// Sample/result stream bundle between a producer/consumer and diff_mc.
interface diff_mc_if #(
  parameter int W  = 4,
  parameter int CW = 1
);
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [CW-1:0] in_ch;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    out_data;
  logic [CW-1:0] out_ch;
  logic          out_first;
  logic          out_err;

  modport slave (
    input  clear, in_valid, in_data, in_ch, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_first, out_err
  );

  modport master (
    output clear, in_valid, in_data, in_ch, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_first, out_err
  );
endinterface

// File: rtl/diff_mc_skid.sv
// Two-entry valid/ready skid buffer; in_ready and out_valid are both registered.
module diff_mc_skid
  import diff_mc_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  skid_state_t state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  T            out_q;
  T            skid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SK_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
    end else begin
      case (state_q)
        SK_EMPTY: begin
          if (in_valid_i) begin
            out_q       <= in_data_i;
            out_valid_q <= 1'b1;
            state_q     <= SK_ONE;
          end
        end
        SK_ONE: begin
          if (out_ready_i && in_valid_i) begin
            out_q <= in_data_i;
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= SK_EMPTY;
          end else if (in_valid_i) begin
            skid_q     <= in_data_i;
            in_ready_q <= 1'b0;
            state_q    <= SK_TWO;
          end
        end
        SK_TWO: begin
          // in_ready is low here, so nothing new can arrive on a drain
          if (out_ready_i) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= SK_ONE;
          end
        end
        default: begin
          state_q     <= SK_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;

endmodule

// File: rtl/diff_mc.sv
// Multi-channel first-difference engine: y = x[n] - x[n-1] per channel ID,
// with first-sample and bad-channel flags, behind a two-entry skid buffer.
module diff_mc
  import diff_mc_pkg::*;
#(
  parameter int INPUT_WIDTH  = 4,
  parameter int NUM_CHANNELS = 2,
  parameter int SIGNED_IN    = 0
) (
  input logic      clk,
  input logic      reset,
  diff_mc_if.slave bus
);

  localparam int W  = INPUT_WIDTH;
  localparam int OW = out_width(W);
  localparam int CW = ch_width(NUM_CHANNELS);

  typedef struct packed {
    logic [OW-1:0] data;
    logic [CW-1:0] ch;
    logic          first;
    logic          err;
  } diff_result_t;

  logic [W-1:0]            hist_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] hist_valid_q;

  logic         in_ready;
  logic         accept;
  logic         ch_ok;
  logic [W-1:0] hist_sel;
  logic         hv_sel;
  diff_result_t res_d;
  diff_result_t res_q;
  logic         out_valid;

  function automatic logic [OW-1:0] ext(input logic [W-1:0] x);
    return (SIGNED_IN != 0) ? {x[W-1], x} : {1'b0, x};
  endfunction

  assign accept = bus.in_valid && in_ready;
  assign ch_ok  = int'(bus.in_ch) < NUM_CHANNELS;

  // Mux instead of a direct index so an out-of-range ID never reads past the array
  always_comb begin
    hist_sel = '0;
    hv_sel   = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (int'(bus.in_ch) == i) begin
        hist_sel = hist_q[i];
        hv_sel   = hist_valid_q[i];
      end
    end
  end

  always_comb begin
    res_d       = '0;
    res_d.ch    = bus.in_ch;
    res_d.err   = !ch_ok;
    res_d.first = ch_ok && (!hv_sel || bus.clear);
    if (ch_ok) begin
      res_d.data = ext(bus.in_data) - (hv_sel ? ext(hist_sel) : '0);
    end
  end

  // A clear coinciding with an accept still leaves that sample as the new history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_valid_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      if (bus.clear) begin
        hist_valid_q <= '0;
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (accept && ch_ok && int'(bus.in_ch) == i) begin
          hist_q[i]       <= bus.in_data;
          hist_valid_q[i] <= 1'b1;
        end
      end
    end
  end

  diff_mc_skid #(
    .T(diff_result_t)
  ) u_skid (
    .clk        (clk),
    .rst        (reset),
    .in_valid_i (bus.in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (res_d),
    .out_valid_o(out_valid),
    .out_ready_i(bus.out_ready),
    .out_data_o (res_q)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = res_q.data;
  assign bus.out_ch    = res_q.ch;
  assign bus.out_first = res_q.first;
  assign bus.out_err   = res_q.err;

endmodule

// File: tb/tb_diff_mc.sv
// Lockstep bench for three diff_mc configurations: (N=2,unsigned), (N=2,signed), (N=3,unsigned).
module tb_diff_mc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic [1:0] in_ch = '0;
  logic       out_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  diff_mc_if #(.W(4), .CW(1)) if0 ();
  diff_mc_if #(.W(4), .CW(1)) if1 ();
  diff_mc_if #(.W(4), .CW(2)) if2 ();

  assign if0.clear = clear;     assign if1.clear = clear;     assign if2.clear = clear;
  assign if0.in_valid = in_valid; assign if1.in_valid = in_valid; assign if2.in_valid = in_valid;
  assign if0.in_data = in_data; assign if1.in_data = in_data; assign if2.in_data = in_data;
  assign if0.in_ch = in_ch[0];  assign if1.in_ch = in_ch[0];  assign if2.in_ch = in_ch;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

  diff_mc #(.INPUT_WIDTH(4), .NUM_CHANNELS(2), .SIGNED_IN(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  diff_mc #(.INPUT_WIDTH(4), .NUM_CHANNELS(2), .SIGNED_IN(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  diff_mc #(.INPUT_WIDTH(4), .NUM_CHANNELS(3), .SIGNED_IN(0)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  logic [2:0] o_rdy, o_vld, o_first, o_err;
  logic [4:0] o_data [3];
  logic [1:0] o_ch [3];

  assign o_rdy   = {if2.in_ready, if1.in_ready, if0.in_ready};
  assign o_vld   = {if2.out_valid, if1.out_valid, if0.out_valid};
  assign o_first = {if2.out_first, if1.out_first, if0.out_first};
  assign o_err   = {if2.out_err, if1.out_err, if0.out_err};
  assign o_data[0] = if0.out_data;
  assign o_data[1] = if1.out_data;
  assign o_data[2] = if2.out_data;
  assign o_ch[0] = {1'b0, if0.out_ch};
  assign o_ch[1] = {1'b0, if1.out_ch};
  assign o_ch[2] = if2.out_ch;

  // Reference model: FIFO of pending results (depth 2) plus per-channel last sample
  typedef struct packed {
    logic [2:0][4:0] data;
    logic [2:0][1:0] ch;
    logic [2:0]      first;
    logic [2:0]      err;
  } exp_t;

  exp_t q[$];
  int   hist [3][3];
  bit   hv [3][3];
  int   nch [3] = '{2, 2, 3};
  bit   sgn [3] = '{1'b0, 1'b1, 1'b0};

  function automatic int sval(input int x, input bit s);
    return (s && x >= 8) ? x - 16 : x;
  endfunction

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      chk("in_ready", k, {7'b0, o_rdy[k]}, {7'b0, q.size() < 2});
      chk("out_valid", k, {7'b0, o_vld[k]}, {7'b0, q.size() > 0});
      if (q.size() > 0) begin
        chk("out_data", k, {3'b0, o_data[k]}, {3'b0, q[0].data[k]});
        chk("out_ch", k, {6'b0, o_ch[k]}, {6'b0, q[0].ch[k]});
        chk("out_first", k, {7'b0, o_first[k]}, {7'b0, q[0].first[k]});
        chk("out_err", k, {7'b0, o_err[k]}, {7'b0, q[0].err[k]});
      end
    end
  endtask

  task automatic model_edge();
    bit   pop;
    bit   push;
    exp_t e;
    int   c;
    int   prev;
    pop  = (q.size() > 0) && out_ready;
    push = in_valid && (q.size() < 2);
    e = '0;
    for (int k = 0; k < 3; k++) begin
      c = (k < 2) ? int'(in_ch[0]) : int'(in_ch);
      e.ch[k] = 2'(c);
      if (c >= nch[k]) begin
        e.err[k] = 1'b1;
      end else begin
        prev = hv[k][c] ? sval(hist[k][c], sgn[k]) : 0;
        e.data[k]  = 5'(sval(int'(in_data), sgn[k]) - prev);
        e.first[k] = !hv[k][c] || clear;
      end
    end
    if (clear) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++) hv[k][j] = 1'b0;
    end
    if (push) begin
      for (int k = 0; k < 3; k++) begin
        c = (k < 2) ? int'(in_ch[0]) : int'(in_ch);
        if (c < nch[k]) begin
          hist[k][c] = int'(in_data);
          hv[k][c]   = 1'b1;
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
  endtask

  task automatic step();
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic send(input int ch, input int d);
    in_valid  = 1'b1;
    in_ch     = 2'(ch);
    in_data   = 4'(d);
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) begin
        hv[k][j]   = 1'b0;
        hist[k][j] = 0;
      end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // Reset values of the result fields
    for (int k = 0; k < 3; k++) begin
      chk("rst_data", k, {3'b0, o_data[k]}, 8'h00);
      chk("rst_ch", k, {6'b0, o_ch[k]}, 8'h00);
      chk("rst_first", k, {7'b0, o_first[k]}, 8'h00);
      chk("rst_err", k, {7'b0, o_err[k]}, 8'h00);
    end
    idle(1);

    // Single channel: 3,7,2
    send(0, 3); send(0, 7); send(0, 2); idle(2);

    // Interleaved channels
    pulse_clear();
    send(0, 5); send(1, 9); send(0, 6); send(1, 1); idle(2);

    // Signed extremes: -8 then 7
    pulse_clear();
    send(0, 8); send(0, 7); idle(2);

    // Backpressure: continuous valid, 4 stalled cycles, then release
    pulse_clear();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_ch   = 2'($urandom_range(0, 1));
      in_data = 4'($urandom_range(0, 15));
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_ch   = 2'($urandom_range(0, 1));
      in_data = 4'($urandom_range(0, 15));
      step();
    end
    idle(3);

    // Clear coinciding with an accepted sample
    pulse_clear();
    send(0, 4); send(0, 6);
    clear = 1'b1;
    send(0, 9);
    clear = 1'b0;
    send(0, 10); idle(1);

    // Reset while a result is pending
    in_valid  = 1'b1;
    in_ch     = 2'd0;
    in_data   = 4'd3;
    out_ready = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("async_rst_out_valid", k, {7'b0, o_vld[k]}, 8'h00);
      chk("async_rst_in_ready", k, {7'b0, o_rdy[k]}, 8'h01);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    send(0, 12); idle(1);

    // Out-of-range channel on the 3-channel instance, then ch0 continues
    send(0, 2); send(3, 5); send(0, 7); idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 15) == 0);
      in_ch     = 2'($urandom_range(0, 3));
      in_data   = 4'($urandom_range(0, 15));
      step();
    end
    clear     = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
